// File: rtl/frame_l4_tx_if.sv
// Byte-stream bundle shared by the payload input and the framed UDP output.
// The master drives every field; the slave only observes.
interface frame_l4_tx_if;
    logic       sof;
    logic       eof;
    logic       val;
    logic       err;
    logic [7:0] data;

    modport master (output sof, eof, val, err, data);
    modport slave  (input  sof, eof, val, err, data);
endinterface

// File: rtl/frame_l4_tx.sv
// UDP transmit framer: buffers one payload, folds the one's-complement checksum,
// then streams the 8-byte UDP header followed by the buffered payload.
module frame_l4_tx #(
    parameter int MAX_PAYLOAD = 1472,
    parameter int ADDR_W      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_l4_tx_if.slave  payload,
    frame_l4_tx_if.master frame,
    input  logic [15:0]   src_port,
    input  logic [15:0]   dst_port,
    input  logic [23:0]   psum,
    output logic          busy,
    output logic [15:0]   len,
    output logic          len_val
);
    localparam logic [15:0] MAX_CNT = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, LOAD, DROP, FOLD1, FOLD2, HDR, DATA} state_t;

    state_t      state;
    logic [15:0] src_lat, dst_lat, frame_len, cks, count, out_idx;
    logic [31:0] acc;
    logic [7:0]  hi_byte, hdr_data, rd_data, hdr_byte;
    logic [2:0]  hdr_idx;
    logic        sof_q, eof_q, val_q, err_q, data_sel;
    logic        start, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0] frame_len_c, cks_c, fold_s2;
    logic [16:0] fold_s;

    logic [7:0] buffer [0:(2**ADDR_W)-1];

    // A SoF byte starts a frame from IDLE and also restarts a partial frame in LOAD.
    assign start       = payload.val && payload.sof && (state == IDLE || state == LOAD);
    assign wr_en       = payload.val && !payload.err &&
                         (start || (state == LOAD && count != MAX_CNT));
    assign wr_addr     = start ? '0 : count[ADDR_W-1:0];
    assign frame_len_c = count + 16'd8;

    always_comb begin
        fold_s  = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
        fold_s2 = fold_s[15:0] + {15'h0, fold_s[16]};
        cks_c   = (~fold_s2 == 16'h0000) ? 16'hFFFF : ~fold_s2;
    end

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            3'd0: hdr_byte = src_lat[15:8];
            3'd1: hdr_byte = src_lat[7:0];
            3'd2: hdr_byte = dst_lat[15:8];
            3'd3: hdr_byte = dst_lat[7:0];
            3'd4: hdr_byte = frame_len[15:8];
            3'd5: hdr_byte = frame_len[7:0];
            3'd6: hdr_byte = cks[15:8];
            3'd7: hdr_byte = cks[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Payload RAM; the read address runs one cycle ahead of the byte on the output.
    always_ff @(posedge clk) begin
        if (wr_en)
            buffer[wr_addr] <= payload.data;
        rd_data <= buffer[out_idx[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_lat   <= '0;
            dst_lat   <= '0;
            frame_len <= '0;
            cks       <= '0;
            count     <= '0;
            out_idx   <= '0;
            acc       <= '0;
            hi_byte   <= '0;
            hdr_data  <= '0;
            hdr_idx   <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            val_q     <= 1'b0;
            err_q     <= 1'b0;
            data_sel  <= 1'b0;
            busy      <= 1'b0;
            len       <= '0;
            len_val   <= 1'b0;
        end else begin
            sof_q   <= 1'b0;
            len_val <= 1'b0;
            err_q   <= 1'b0;
            if (start) begin
                if (payload.err) begin
                    err_q <= 1'b1;
                    state <= payload.eof ? IDLE : DROP;
                    busy  <= !payload.eof;
                end else begin
                    src_lat <= src_port;
                    dst_lat <= dst_port;
                    count   <= 16'd1;
                    hi_byte <= payload.data;
                    acc     <= {8'h0, psum} + {16'h0, src_port} + {16'h0, dst_port} +
                               (payload.eof ? {16'h0, payload.data, 8'h00} : 32'h0);
                    state   <= payload.eof ? FOLD1 : LOAD;
                    busy    <= payload.eof;
                end
            end else begin
                case (state)
                    LOAD: if (payload.val) begin
                        if (payload.err || count == MAX_CNT) begin
                            err_q <= 1'b1;
                            state <= payload.eof ? IDLE : DROP;
                            busy  <= !payload.eof;
                        end else begin
                            count <= count + 16'd1;
                            // Even index opens a word; an odd-length tail is padded with zero.
                            if (!count[0]) begin
                                hi_byte <= payload.data;
                                if (payload.eof)
                                    acc <= acc + {16'h0, payload.data, 8'h00};
                            end else begin
                                acc <= acc + {16'h0, hi_byte, payload.data};
                            end
                            if (payload.eof) begin
                                state <= FOLD1;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    DROP: if (payload.val && payload.eof) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    FOLD1: begin
                        frame_len <= frame_len_c;
                        acc       <= acc + {15'h0, frame_len_c, 1'b0};
                        state     <= FOLD2;
                    end
                    FOLD2: begin
                        cks      <= cks_c;
                        len      <= frame_len;
                        len_val  <= 1'b1;
                        sof_q    <= 1'b1;
                        val_q    <= 1'b1;
                        hdr_data <= src_lat[15:8];
                        hdr_idx  <= 3'd1;
                        state    <= HDR;
                    end
                    HDR: begin
                        hdr_data <= hdr_byte;
                        hdr_idx  <= hdr_idx + 3'd1;
                        if (hdr_idx == 3'd7) begin
                            out_idx <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (out_idx != count) begin
                            data_sel <= 1'b1;
                            out_idx  <= out_idx + 16'd1;
                            eof_q    <= (out_idx == count - 16'd1);
                        end else begin
                            val_q    <= 1'b0;
                            eof_q    <= 1'b0;
                            data_sel <= 1'b0;
                            hdr_data <= '0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign frame.sof  = sof_q;
    assign frame.eof  = eof_q;
    assign frame.val  = val_q;
    assign frame.err  = err_q;
    assign frame.data = data_sel ? rd_data : hdr_data;
endmodule

// File: tb/tb_frame_l4_tx.sv
// Directed bench for frame_l4_tx: a table of frames with hand-computed checksums,
// plus sequences for drops, restart, back-to-back frames and mid-frame reset.
module tb_frame_l4_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] src_port = '0, dst_port = '0;
    logic [23:0] psum = '0;
    logic        busy, len_val;
    logic [15:0] len;

    frame_l4_tx_if payload_if ();
    frame_l4_tx_if frame_if ();

    frame_l4_tx dut (
        .clk(clk), .rst_n(rst_n),
        .payload(payload_if), .frame(frame_if),
        .src_port(src_port), .dst_port(dst_port), .psum(psum),
        .busy(busy), .len(len), .len_val(len_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  start;
        logic [7:0]  step;
        logic [15:0] src;
        logic [15:0] dst;
        logic [23:0] psum;
        logic [15:0] cks;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0, passed = 0;
    int   cyc = 0, val_total = 0, err_total = 0, last_err_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_if.val === 1'b1) val_total <= val_total + 1;
        if (frame_if.err === 1'b1) begin
            err_total    <= err_total + 1;
            last_err_cyc <= cyc;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input vec_t v, input int i);
        return v.start + 8'(int'(v.step) * i);
    endfunction

    // Drives v.n bytes starting at the current negedge; returns the posedge count
    // at which the last byte was accepted and the drive cycle of byte mark_idx.
    task automatic apply_stimulus(input vec_t v, input int mark_idx, input bit inject,
                                  input bit term, output int last_edge, output int mark_cyc);
        src_port = v.src;
        dst_port = v.dst;
        psum     = v.psum;
        mark_cyc = -1;
        for (int i = 0; i < v.n; i++) begin
            payload_if.val  = 1'b1;
            payload_if.sof  = (i == 0);
            payload_if.eof  = term && (i == v.n - 1);
            payload_if.err  = inject && (i == mark_idx);
            payload_if.data = pat(v, i);
            if (i == mark_idx) mark_cyc = cyc;
            @(negedge clk);
        end
        payload_if.val  = 1'b0;
        payload_if.sof  = 1'b0;
        payload_if.eof  = 1'b0;
        payload_if.err  = 1'b0;
        payload_if.data = 8'h00;
        last_edge = cyc;
    endtask

    task automatic expect_frame(input vec_t v, input int last_edge, input string tag);
        int          waited = 0, nbytes = 0, bad = 0, gaps = 0, eof_cyc = -1;
        logic [63:0] hdr = '0;
        logic [7:0]  b;
        while (frame_if.sof !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output({tag, " sof seen"}, 64'(frame_if.sof), 64'd1);
        if (frame_if.sof !== 1'b1) return;
        check_output({tag, " sof cycle"}, 64'(cyc), 64'(last_edge + 2));
        check_output({tag, " len_val"}, 64'(len_val), 64'd1);
        check_output({tag, " len"}, 64'(len), 64'(v.n + 8));
        for (int k = 0; k < v.n + 12; k++) begin
            if (frame_if.val !== 1'b1) gaps++;
            b = frame_if.data;
            if (nbytes < 8) hdr = {hdr[55:0], b};
            else if (b !== pat(v, nbytes - 8)) bad++;
            nbytes++;
            if (frame_if.eof === 1'b1) begin
                eof_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check_output({tag, " header"}, hdr, {v.src, v.dst, 16'(v.n + 8), v.cks});
        check_output({tag, " byte count"}, 64'(nbytes), 64'(v.n + 8));
        check_output({tag, " payload errors"}, 64'(bad), 64'd0);
        check_output({tag, " val gaps"}, 64'(gaps), 64'd0);
        check_output({tag, " eof cycle"}, 64'(eof_cyc), 64'(last_edge + 2 + 8 + v.n - 1));
        @(negedge clk);
        check_output({tag, " busy low after eof"}, 64'(busy), 64'd0);
        check_output({tag, " val low after eof"}, 64'(frame_if.val), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   le, le_b, mk, e0, v0, guard;
        payload_if.val = 1'b0;
        payload_if.sof = 1'b0;
        payload_if.eof = 1'b0;
        payload_if.err = 1'b0;
        payload_if.data = 8'h00;

        vecs[0] = '{4,    8'h01, 8'h01, 16'h1234, 16'h5678, 24'h000000, 16'h9335};
        vecs[1] = '{1,    8'hAB, 8'h01, 16'h1234, 16'h5678, 24'h000000, 16'hEC40};
        vecs[2] = '{4,    8'h01, 8'h01, 16'h1234, 16'h5678, 24'h009335, 16'hFFFF};
        vecs[3] = '{3,    8'h10, 8'h01, 16'h0001, 16'h0002, 24'h000100, 16'hDCD5};
        vecs[4] = '{2,    8'hFF, 8'h01, 16'hFFFF, 16'hFFFF, 24'hFFFFFF, 16'hFFEB};
        vecs[5] = '{1472, 8'h5A, 8'h00, 16'h1234, 16'h5678, 24'h000000, 16'hC7FF};

        repeat (3) @(negedge clk);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset len", 64'(len), 64'd0);
        check_output("reset val", 64'(frame_if.val), 64'd0);
        check_output("reset data", 64'(frame_if.data), 64'd0);
        check_output("reset err", 64'(frame_if.err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], -1, 1'b0, 1'b1, le, mk);
            check_output($sformatf("vec%0d busy rise", i), 64'(busy), 64'd1);
            expect_frame(vecs[i], le, $sformatf("vec%0d", i));
        end

        // A second SoF inside a partial frame restarts it without an error pulse.
        e0 = err_total;
        v = vecs[0];
        v.n = 3;
        apply_stimulus(v, -1, 1'b0, 1'b0, le, mk);
        apply_stimulus(vecs[0], -1, 1'b0, 1'b1, le, mk);
        expect_frame(vecs[0], le, "restart");
        check_output("restart no err", 64'(err_total - e0), 64'd0);

        // ErrIn on the second byte of a 10-byte frame.
        v = vecs[0];
        v.n = 10;
        e0 = err_total;
        v0 = val_total;
        apply_stimulus(v, 1, 1'b1, 1'b1, le, mk);
        repeat (20) @(negedge clk);
        check_output("errin pulses", 64'(err_total - e0), 64'd1);
        check_output("errin no output", 64'(val_total - v0), 64'd0);
        check_output("errin pulse cycle", 64'(last_err_cyc), 64'(mk + 1));
        apply_stimulus(vecs[3], -1, 1'b0, 1'b1, le, mk);
        expect_frame(vecs[3], le, "after errin");

        // One byte over the payload limit.
        v = vecs[5];
        v.n = 1473;
        e0 = err_total;
        v0 = val_total;
        apply_stimulus(v, 1472, 1'b0, 1'b1, le, mk);
        repeat (20) @(negedge clk);
        check_output("oversize pulses", 64'(err_total - e0), 64'd1);
        check_output("oversize no output", 64'(val_total - v0), 64'd0);
        check_output("oversize pulse cycle", 64'(last_err_cyc), 64'(mk + 1));

        // Junk SoF bytes while busy are ignored; the next frame starts as busy falls.
        apply_stimulus(vecs[0], -1, 1'b0, 1'b1, le, mk);
        le_b = -1;
        fork
            expect_frame(vecs[0], le, "b2b A");
            begin
                guard = 0;
                while (busy === 1'b1 && guard < 60) begin
                    payload_if.val  = 1'b1;
                    payload_if.sof  = 1'b1;
                    payload_if.eof  = 1'b1;
                    payload_if.data = 8'hEE;
                    @(negedge clk);
                    guard++;
                end
                apply_stimulus(vecs[3], -1, 1'b0, 1'b1, le_b, mk);
            end
        join
        check_output("b2b busy fell", 64'(guard < 60), 64'd1);
        expect_frame(vecs[3], le_b, "b2b B");
        v0 = val_total;
        repeat (20) @(negedge clk);
        check_output("b2b no junk frame", 64'(val_total - v0), 64'd0);

        // Reset in the middle of the payload phase.
        v = vecs[3];
        v.n = 10;
        apply_stimulus(v, -1, 1'b0, 1'b1, le, mk);
        guard = 0;
        while (frame_if.sof !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_output("midreset sof seen", 64'(frame_if.sof), 64'd1);
        repeat (12) @(negedge clk);
        check_output("midreset in data", 64'(frame_if.val), 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("midreset val", 64'(frame_if.val), 64'd0);
        check_output("midreset data", 64'(frame_if.data), 64'd0);
        check_output("midreset busy", 64'(busy), 64'd0);
        check_output("midreset len", 64'(len), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(vecs[0], -1, 1'b0, 1'b1, le, mk);
        expect_frame(vecs[0], le, "after reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
